// File: rtl/slave_mem_responder_if.sv
// rtl/slave_mem_responder_if.sv - request/response bus between the slave-side fifo and the memory responder
interface slave_mem_responder_if;
  logic         req_cmd;
  logic [26:0]  req_addr;
  logic [127:0] req_data;
  logic         req_en;
  logic         req_rdy;
  logic [127:0] rsp_data;
  logic         rsp_en;
  logic         rsp_rdy;

  modport master (
    output req_cmd, req_addr, req_data, req_en, rsp_rdy,
    input  req_rdy, rsp_data, rsp_en
  );

  modport slave (
    input  req_cmd, req_addr, req_data, req_en, rsp_rdy,
    output req_rdy, rsp_data, rsp_en
  );
endinterface

// File: rtl/slave_mem_responder.sv
// rtl/slave_mem_responder.sv - behavioural 128-bit memory endpoint with fixed read latency and in-order response queue
// Optional SLAVE_MEM_INIT_EN: zero-fill the whole array in an INIT state after reset before accepting requests.
module slave_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int RSPQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_mem_responder_if.slave  bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(RSPQ_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = RSPQ_DEPTH[PTR_W:0];

  typedef enum logic {ST_RUN = 1'b0, ST_INIT = 1'b1} state_e;

`ifdef SLAVE_MEM_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_RUN;
`endif

  state_e state_q, state_d;
  logic [PTR_W:0]        cnt_q, cnt_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic [LATENCY-1:0]    pv_q;
  logic [127:0]          pd_q [LATENCY];
  logic [127:0]          fifo_q [RSPQ_DEPTH];
  logic [127:0]          mem_q [WORDS];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  req_rdy;
  logic                  req_acc, rd_acc, wr_acc, rsp_hs, push;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [127:0]          mem_wdata;
  logic                  unused_addr_bits;

  // Sub-word offset and high address bits are don't-care; addresses alias.
  assign idx              = bus.req_addr[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^{bus.req_addr[2:0], bus.req_addr[26:DEPTH_LOG2+3]};

  assign req_rdy     = rstn && (state_q == ST_RUN) && (cnt_q != CNT_FULL);
  assign bus.req_rdy = req_rdy;
  assign req_acc     = bus.req_en && req_rdy;
  assign rd_acc      = req_acc && bus.req_cmd;
  assign wr_acc      = req_acc && !bus.req_cmd;
  assign rsp_hs      = bus.rsp_en && bus.rsp_rdy;
  assign push        = pv_q[LATENCY-1];

  assign bus.rsp_en   = (wr_ptr_q != rd_ptr_q);
  assign bus.rsp_data = fifo_q[rd_ptr_q[PTR_W-1:0]];

`ifdef SLAVE_MEM_INIT_EN
  logic [DEPTH_LOG2-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) init_cnt_q <= '0;
    else       init_cnt_q <= init_cnt_d;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = wr_acc;
    mem_widx   = idx;
    mem_wdata  = bus.req_data;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      mem_we     = 1'b1;
      mem_widx   = init_cnt_q;
      mem_wdata  = '0;
      if (init_cnt_q == '1) state_d = ST_RUN;
    end
  end
`else
  always_comb begin
    state_d   = ST_RUN;
    mem_we    = wr_acc;
    mem_widx  = idx;
    mem_wdata = bus.req_data;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, rsp_hs};
    cnt_d    = cnt_q;
    case ({rd_acc, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Memory is deliberately unreset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    pd_q[0] <= mem_q[idx];
    for (int i = 1; i < LATENCY; i++) pd_q[i] <= pd_q[i-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RSPQ_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) pv_q[i] <= pv_q[i-1];
      // Credits guarantee a free slot whenever the pipeline delivers.
      if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= pd_q[LATENCY-1];
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_slave_mem_responder.sv
// tb/tb_slave_mem_responder.sv - directed scoreboard bench for slave_mem_responder (default build)
module tb_slave_mem_responder;

  logic clk = 1'b0;
  logic rstn;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [127:0] sb[$];
  logic [127:0] mem_m [1024];

  localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DA5 = {16{8'hA5}};

  slave_mem_responder_if bus ();

  slave_mem_responder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: handshakes are decided at the next rising edge, inputs are stable here.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.rsp_en && bus.rsp_rdy) begin
        if (sb.size() == 0) check("unexpected_rsp", 128'd1, 128'd0);
        else check("rsp_data", bus.rsp_data, sb.pop_front());
      end
      if (bus.req_en && bus.req_rdy) begin
        if (!bus.req_cmd) mem_m[bus.req_addr[12:3]] = bus.req_data;
        else sb.push_back(mem_m[bus.req_addr[12:3]]);
      end
    end
  end

  task automatic req(input logic cmd, input logic [26:0] a, input logic [127:0] d);
    int n = 0;
    bus.req_cmd  = cmd;
    bus.req_addr = a;
    bus.req_data = d;
    bus.req_en   = 1'b1;
    @(negedge clk);
    while (!bus.req_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_rdy) check("req_accept_timeout", {127'd0, bus.req_rdy}, 128'd1);
    @(posedge clk); #1;
    bus.req_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", {127'd0, sb.size() == 0}, 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn         = 1'b0;
    bus.req_cmd  = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_en   = 1'b0;
    bus.rsp_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_en",   {127'd0, bus.rsp_en},  128'd0);
    check("rst_rsp_data", bus.rsp_data,          128'd0);
    check("rst_req_rdy",  {127'd0, bus.req_rdy}, 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("run_req_rdy", {127'd0, bus.req_rdy}, 128'd1);
    @(posedge clk); #1;

    // 1: write then read back with exact latency
    req(1'b0, 27'h0000040, D1);
    req(1'b1, 27'h0000040, '0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_rsp_en_%0d", k), {127'd0, bus.rsp_en}, {127'd0, k == 4});
    end
    check("lat_rsp_data", bus.rsp_data, D1);
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    wait_drain();

    // 2: aliasing
    req(1'b0, 27'h0000010, DA5);
    req(1'b1, 27'h0000017, '0);
    req(1'b1, 27'h0002010, '0);
    wait_drain();

    // 3: credit exhaustion with stalled responses
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) req(1'b0, 27'(i * 8), {4{32'hC0DE_0000 + 32'(i)}});
    for (int i = 0; i < 4; i++) req(1'b1, 27'(i * 8), '0);
    bus.req_cmd  = 1'b1;
    bus.req_addr = 27'd32;
    bus.req_en   = 1'b1;
    @(negedge clk);
    check("full_req_rdy_0", {127'd0, bus.req_rdy}, 128'd0);
    repeat (5) @(negedge clk);
    check("full_req_rdy_1", {127'd0, bus.req_rdy}, 128'd0);
    check("full_rsp_en",    {127'd0, bus.rsp_en},  128'd1);
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    req(1'b1, 27'd32, '0);
    req(1'b1, 27'd40, '0);
    wait_drain();

    // 4: simultaneous accept and pop at cnt==3
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) req(1'b1, 27'(i * 8), '0);
    repeat (8) @(posedge clk);
    #1;
    bus.rsp_rdy  = 1'b1;
    bus.req_cmd  = 1'b1;
    bus.req_addr = 27'd24;
    bus.req_en   = 1'b1;
    @(negedge clk);
    check("cnt3_req_rdy", {127'd0, bus.req_rdy}, 128'd1);
    @(posedge clk); #1;
    bus.rsp_rdy  = 1'b0;
    bus.req_addr = 27'd32;
    @(negedge clk);
    check("cnt3_hold_req_rdy", {127'd0, bus.req_rdy}, 128'd1);
    @(posedge clk); #1;
    bus.req_en = 1'b0;
    @(negedge clk);
    check("cnt4_req_rdy", {127'd0, bus.req_rdy}, 128'd0);
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    wait_drain();

    // 5: reset with responses queued and in flight
    bus.rsp_rdy = 1'b0;
    req(1'b1, 27'h0000040, '0);
    req(1'b1, 27'h0000010, '0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_rsp_en", {127'd0, bus.rsp_en}, 128'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_rsp_en",  {127'd0, bus.rsp_en},  128'd0);
    check("mid_rst_req_rdy", {127'd0, bus.req_rdy}, 128'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.rsp_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale_rsp", {127'd0, bus.rsp_en}, 128'd0);
    @(posedge clk); #1;
    req(1'b1, 27'h0000040, '0);
    repeat (5) @(negedge clk);
    check("post_rst_data", bus.rsp_data, D1);
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
